// File: rtl/rsa_exp_ctrl_pkg.sv
// rsa_pkg: shared types, default sizing and op-count helper for the RSA exponentiation sequencer.
// Optional feature macro: RSA_CONST_TIME_EN (multiply step on every exponent bit).
package rsa_pkg;

    localparam int WIDTH_DEF   = 10;
    localparam int MMM_LAT_DEF = 11;

`ifdef RSA_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_X, S_PRE_ACC, S_SQUARE, S_MULT, S_POST, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_CLR, P_LOAD, P_RUN, P_CAP
    } phase_t;

    // Montgomery operations per exponentiation: two conversions in, one out, one square per bit plus the multiplies
    function automatic int unsigned n_ops(input int unsigned width, input logic [31:0] e);
        return 3 + width + (CONST_TIME ? width : int'($countones(e)));
    endfunction

endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// rsa_exp_ctrl_if: host request/response signals and the mmm_unit control/operand bus.
// slave = the sequencer, master = whoever drives requests and models mmm_unit.
interface rsa_exp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] msg;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] mod;
    logic [WIDTH-1:0] r2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             mmm_en;
    logic             mmm_rst_n;
    logic             mmm_ld_a;
    logic             mmm_ld_r;
    logic             mmm_lock;
    logic [WIDTH-1:0] mmm_a;
    logic [WIDTH-1:0] mmm_b;
    logic [WIDTH-1:0] mmm_m;
    logic [WIDTH-1:0] mmm_r;

    modport slave (
        input  en, start, msg, exp, mod, r2, mmm_r,
        output busy, done, result, mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock,
               mmm_a, mmm_b, mmm_m
    );

    modport master (
        output en, start, msg, exp, mod, r2, mmm_r,
        input  busy, done, result, mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock,
               mmm_a, mmm_b, mmm_m
    );
endinterface

// File: rtl/rsa_exp_ctrl_mmm_seq.sv
// mmm_seq: runs one Montgomery multiply on mmm_unit (CLR, LOAD, RUN, CAP) and returns the product reduced below the modulus.
module mmm_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MMM_LAT = MMM_LAT_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_en,
    input  logic             i_go,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_m,
    input  logic [WIDTH-1:0] i_mmm_r,
    output logic             o_idle,
    output logic             o_ack,
    output logic [WIDTH-1:0] o_prod,
    output logic             o_rst_n,
    output logic             o_ld_a,
    output logic             o_ld_r,
    output logic             o_lock,
    output logic [WIDTH-1:0] o_mmm_a,
    output logic [WIDTH-1:0] o_mmm_b,
    output logic [WIDTH-1:0] o_mmm_m
);
    localparam int CW = (MMM_LAT > 2) ? $clog2(MMM_LAT) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(MMM_LAT - 2);

    phase_t           r_phase;
    phase_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   w_diff;

    // phase register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_phase <= P_IDLE;
        else if (i_en)
            r_phase <= w_next;
    end

    // phase sequencing; RUN lasts MMM_LAT-1 cycles
    always_comb begin
        w_next = r_phase;
        case (r_phase)
            P_IDLE:  w_next = i_go ? P_CLR : P_IDLE;
            P_CLR:   w_next = P_LOAD;
            P_LOAD:  w_next = P_RUN;
            P_RUN:   w_next = (r_cnt == RUN_LAST) ? P_CAP : P_RUN;
            P_CAP:   w_next = P_IDLE;
            default: w_next = P_IDLE;
        endcase
    end

    // run counter and operand hold registers, operands stay fixed from CLR through CAP
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= '0;
        end else if (i_en) begin
            r_cnt <= (r_phase == P_RUN) ? r_cnt + 1'b1 : '0;
            if (r_phase == P_IDLE && i_go) begin
                r_a <= i_a;
                r_b <= i_b;
                r_m <= i_m;
            end
        end
    end

    // strobes decoded from the phase; product is brought from [0, 2m) into [0, m)
    always_comb begin
        w_diff  = {1'b0, i_mmm_r} - {1'b0, r_m};
        o_prod  = w_diff[WIDTH] ? i_mmm_r : w_diff[WIDTH-1:0];
        o_idle  = r_phase == P_IDLE;
        o_ack   = r_phase == P_CAP;
        o_rst_n = r_phase != P_CLR;
        o_ld_a  = r_phase == P_LOAD;
        o_ld_r  = r_phase == P_CAP;
        o_lock  = r_phase == P_CAP;
        o_mmm_a = r_a;
        o_mmm_b = r_b;
        o_mmm_m = r_m;
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: left-to-right square-and-multiply modular exponentiation over mmm_unit, with Montgomery conversion in and out.
// Define RSA_CONST_TIME_EN to perform the multiply step for every exponent bit, discarding it when the bit is 0.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MMM_LAT = MMM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    rsa_exp_ctrl_if.slave     bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_msg;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_xb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             w_go;
    logic             w_idle;
    logic             w_ack;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_prod;

    mmm_seq #(
        .WIDTH   (WIDTH),
        .MMM_LAT (MMM_LAT)
    ) u_seq (
        .clk     (clk),
        .rstb    (rstb),
        .i_en    (bus.en),
        .i_go    (w_go),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_m     (r_mod),
        .i_mmm_r (bus.mmm_r),
        .o_idle  (w_idle),
        .o_ack   (w_ack),
        .o_prod  (w_prod),
        .o_rst_n (bus.mmm_rst_n),
        .o_ld_a  (bus.mmm_ld_a),
        .o_ld_r  (bus.mmm_ld_r),
        .o_lock  (bus.mmm_lock),
        .o_mmm_a (bus.mmm_a),
        .o_mmm_b (bus.mmm_b),
        .o_mmm_m (bus.mmm_m)
    );

    assign bus.mmm_en = bus.en;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    // top state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_state <= S_IDLE;
        else if (bus.en)
            r_state <= w_next;
    end

    // step through the exponent one bit per square, advancing only when the current product is captured
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = bus.start ? S_PRE_X : S_IDLE;
            S_PRE_X:   w_next = w_ack ? S_PRE_ACC : S_PRE_X;
            S_PRE_ACC: w_next = w_ack ? S_SQUARE : S_PRE_ACC;
`ifdef RSA_CONST_TIME_EN
            S_SQUARE:  w_next = w_ack ? S_MULT : S_SQUARE;
`else
            S_SQUARE:  w_next = !w_ack ? S_SQUARE :
                                r_exp[r_idx] ? S_MULT :
                                (r_idx == '0) ? S_POST : S_SQUARE;
`endif
            S_MULT:    w_next = !w_ack ? S_MULT : (r_idx == '0) ? S_POST : S_SQUARE;
            S_POST:    w_next = w_ack ? S_DONE : S_POST;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // operand selection per step and launch of a new multiply whenever the sequencer is free
    always_comb begin
        w_go = w_idle && (r_state inside {S_PRE_X, S_PRE_ACC, S_SQUARE, S_MULT, S_POST});
        w_a  = (r_state == S_PRE_X)   ? r_msg :
               (r_state == S_PRE_ACC) ? ONE   : r_acc;
        w_b  = (r_state == S_PRE_X || r_state == S_PRE_ACC) ? r_r2 :
               (r_state == S_MULT)    ? r_xb  :
               (r_state == S_POST)    ? ONE   : r_acc;
    end

    // operand latch, bit index, xb/acc capture and result/handshake registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_idx    <= '0;
            r_msg    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_r2     <= '0;
            r_xb     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.en) begin
            r_done <= r_state == S_DONE;
            if (r_state == S_IDLE && bus.start) begin
                r_msg  <= bus.msg;
                r_exp  <= bus.exp;
                r_mod  <= bus.mod;
                r_r2   <= bus.r2;
                r_idx  <= IW'(WIDTH - 1);
                r_busy <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_result <= r_acc;
                r_busy   <= 1'b0;
            end
            if (w_ack && r_state == S_PRE_X)
                r_xb <= w_prod;
            else if (w_ack && (r_state != S_MULT || r_exp[r_idx]))
                r_acc <= w_prod;
            if (w_ack && w_next == S_SQUARE && r_state != S_PRE_ACC)
                r_idx <= r_idx - 1'b1;
        end
    end

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Modular-exponentiation sequencer for the RSA datapath. Computes result = msg^exp mod mod by left-to-right square-and-multiply, issuing every multiplication as a Montgomery operation on the existing mmm_unit. It drives that unit's control strobes and operands and consumes its R output. Inputs and outputs are in the normal domain; Montgomery-domain conversion is performed internally using the precomputed constant r2 = 2^(2·WIDTH) mod mod.

## Interface
- WIDTH, 10: operand width; also the number of exponent bits scanned.
- MMM_LAT, 11: shift cycles per Montgomery operation, counted from the mmm_ld_a cycle to a valid mmm_r.
- clk  in  1  clock.
- rstb  in  1  reset. Asynchronous, active-low.
- en  in  1  global enable; low freezes every register and counter. Forwarded unchanged as mmm_en.
- start  in  1  pulse that requests an exponentiation. Accepted only in IDLE with en high.
- msg, exp, mod, r2  in  WIDTH  operands. Latched on the accepting cycle. mod must be odd and greater than 1.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  final value. Held until the next acceptance.
- mmm_en  out  1  enable to mmm_unit.
- mmm_rst_n  out  1  active-low clear of mmm_unit state.
- mmm_ld_a, mmm_ld_r, mmm_lock  out  1  load-A, load-result and result-lock strobes.
- mmm_a, mmm_b, mmm_m  out  WIDTH  multiplier operands and modulus.
- mmm_r  in  WIDTH  Montgomery product returned by mmm_unit. Range is [0, 2·mod).

## Operation
- Top FSM states: IDLE, PRE_X, PRE_ACC, SQUARE, MULT, POST, DONE.
- IDLE: on start, latch the operands, set bit index i = WIDTH-1, go to PRE_X.
- PRE_X: xb = MMM(msg, r2).
- PRE_ACC: acc = MMM(1, r2), which equals R mod mod.
- SQUARE: acc = MMM(acc, acc). Next state:
  - MULT if exp[i] = 1.
  - Otherwise POST if i = 0.
  - Otherwise decrement i and stay in SQUARE.
- MULT: acc = MMM(acc, xb). Next state is POST if i = 0; otherwise decrement i and go to SQUARE.
- POST: acc = MMM(acc, 1).
- Every captured product is reduced: if mmm_r >= mod, store mmm_r - mod; otherwise store mmm_r. This gives WIDTH+1-bit compare and subtract.
- DONE: result <= acc; pulse done; return to IDLE.
- Each MMM operation is a phase sequence: CLR → LOAD → RUN → CAP.
  - CLR: mmm_rst_n = 0 for 1 cycle.
  - LOAD: mmm_ld_a = 1 for 1 cycle; mmm_a, mmm_b and mmm_m are valid and held through CAP.
  - RUN: MMM_LAT-1 cycles.
  - CAP: mmm_ld_r = 1 and mmm_lock = 1; mmm_r is sampled on this edge.
- start during busy is ignored. The operand inputs may change freely after acceptance.
- exp = 0: no MULT operations occur; result = 1.

## Timing
- Reset values:
  - busy, done, mmm_ld_a, mmm_ld_r, mmm_lock = 0.
  - mmm_rst_n = 1.
  - result, mmm_a, mmm_b, mmm_m = 0.
  - FSM in IDLE.
- Reset asserted mid-operation: abort immediately to the reset values. No done pulse.
- One MMM operation takes MMM_LAT+3 = 14 cycles.
- Operation count N_ops = 3 + WIDTH + popcount(exp).
- done asserts N_ops·(MMM_LAT+3)+1 rising edges after the accepting edge. en-low cycles are added 1:1.
- result updates on the same edge that raises done. busy falls on that edge.
- A new start is accepted the cycle after done.

## Configuration
- RSA_CONST_TIME_EN defined:
  - MULT is executed for every exponent bit.
  - When exp[i] = 0 the product is computed and discarded; acc is unchanged.
  - N_ops = 3 + 2·WIDTH, independent of exp.
- RSA_CONST_TIME_EN undefined: MULT runs only for exp bits equal to 1, as described in Operation.

## Structure
- Shared package rsa_pkg holds:
  - The top FSM state enum and MMM phase enum.
  - Default WIDTH and MMM_LAT.
  - An op-count helper function used by the bench.
- Sub-module mmm_seq owns the CLR/LOAD/RUN/CAP phase counter, the strobe generation and the reduce-on-capture. It takes a go pulse and returns a one-cycle ack with the reduced product.
- rsa_exp_ctrl keeps the top FSM, bit index, xb/acc registers and operand muxing.

## Test plan
The bench uses a behavioural MMM model that returns a·b·2^-10 mod m, plus m when (a+b) is odd, to exercise the reduction path.
- msg=4, exp=3, mod=11, r2=1 → result=9; done after (3+10+2)·14+1 = 211 cycles.
- msg=2, exp=10, mod=13, r2=9 → result=10.
- exp=0, mod=13, r2=9, any msg → result=1; 13 ops, done at 183 cycles.
- start pulsed again at cycle 50 of a run → ignored; single done; result unchanged versus an undisturbed run.
- rstb low at cycle 100 → busy=0, all mmm strobes 0, mmm_rst_n=1 at once. A following start completes correctly.
- With RSA_CONST_TIME_EN: exp=10'b1000000001 and exp=10'b1111111111 both give done at 23·14+1 = 323 cycles, with correct results.
